// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// Programmable clock divider: Y is a 50% duty clock with half-period DIV+1 CLK cycles.
// DIV is captured only at each Y rising edge, and a stop request always lets the current period finish.
module gf180mcu_osu_sc_12t_clkdiv #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    output logic             Y,
    output logic             PULSE,
    output logic             ACTIVE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             y_q, y_d;
    logic             pulse_q, pulse_d;
    logic             active_q, active_d;
    logic             phase_done;

    // The comparison happens before the increment, so DIV = all-ones never wraps the counter.
    assign phase_done = (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        y_d     = y_q;
        pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                y_d   = 1'b0;
                if (EN) begin
                    state_d = HIGH;
                    y_d     = 1'b1;
                    pulse_d = 1'b1;
                    div_d   = DIV;
                end
            end
            HIGH: begin
                y_d = 1'b1;
                if (phase_done) begin
                    state_d = LOW;
                    y_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            LOW: begin
                y_d = 1'b0;
                if (!phase_done) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else if (EN) begin
                    // Go straight into the next high phase so there is no gap between periods.
                    state_d = HIGH;
                    y_d     = 1'b1;
                    pulse_d = 1'b1;
                    div_d   = DIV;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                y_d     = 1'b0;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            y_q      <= 1'b0;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            y_q      <= y_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
        end
    end

    assign Y      = y_q;
    assign PULSE  = pulse_q;
    assign ACTIVE = active_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv
// Directed bench for the clock divider: a vector table plus hand-written sequences
// for a mid-period DIV change and the full-range DIV=255 period.
module tb_gf180mcu_osu_sc_12t_clkdiv;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             Y;
    logic             PULSE;
    logic             ACTIVE;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic             rst;
        logic             en;
        logic [WIDTH-1:0] div;
        logic             y;
        logic             pulse;
        logic             active;
    } vec_t;

    vec_t vecs[$];

    gf180mcu_osu_sc_12t_clkdiv #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .DIV    (DIV),
        .Y      (Y),
        .PULSE  (PULSE),
        .ACTIVE (ACTIVE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic en, input int div,
                                input logic y, input logic pulse, input logic active);
        vec_t v;
        v.rst    = rst;
        v.en     = en;
        v.div    = WIDTH'(div);
        v.y      = y;
        v.pulse  = pulse;
        v.active = active;
        vecs.push_back(v);
    endfunction

    // Inputs change 1ns after an edge; outputs are sampled at the same point, after the edge settles.
    task automatic edge_wait();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic exp_y;
        logic exp_p;
        int   max_cnt;

        RST = 1'b1;
        EN  = 1'b0;
        DIV = '0;

        // DIV=3 free-running from reset release, including the reset-state check.
        add(1, 1, 3, 0, 0, 0);
        add(0, 1, 3, 1, 1, 1);
        add(0, 1, 3, 1, 0, 1);
        add(0, 1, 3, 1, 0, 1);
        add(0, 1, 3, 1, 0, 1);
        add(0, 1, 3, 0, 0, 1);
        add(0, 1, 3, 0, 0, 1);
        add(0, 1, 3, 0, 0, 1);
        add(0, 1, 3, 0, 0, 1);
        add(0, 1, 3, 1, 1, 1);
        add(0, 1, 3, 1, 0, 1);
        // DIV=0: Y toggles every cycle, with a PULSE every second cycle.
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 1, 1, 1);
        add(0, 1, 0, 0, 0, 1);
        // DIV=4 with EN dropped during the first high cycle: the full period completes, then the divider idles.
        add(1, 1, 4, 0, 0, 0);
        add(0, 1, 4, 1, 1, 1);
        add(0, 0, 4, 1, 0, 1);
        add(0, 0, 4, 1, 0, 1);
        add(0, 0, 4, 1, 0, 1);
        add(0, 0, 4, 1, 0, 1);
        add(0, 0, 4, 0, 0, 1);
        add(0, 0, 4, 0, 0, 1);
        add(0, 0, 4, 0, 0, 1);
        add(0, 0, 4, 0, 0, 1);
        add(0, 0, 4, 0, 0, 1);
        add(0, 0, 4, 0, 0, 0);
        add(0, 0, 4, 0, 0, 0);
        // DIV=3 with reset on the second high cycle, then restart on the first free edge.
        add(1, 1, 3, 0, 0, 0);
        add(0, 1, 3, 1, 1, 1);
        add(0, 1, 3, 1, 0, 1);
        add(1, 1, 3, 0, 0, 0);
        add(0, 1, 3, 1, 1, 1);
        add(0, 1, 3, 1, 0, 1);
        // DIV=2 with EN re-raised before the last low cycle: the next period follows with no gap.
        add(1, 1, 2, 0, 0, 0);
        add(0, 1, 2, 1, 1, 1);
        add(0, 0, 2, 1, 0, 1);
        add(0, 0, 2, 1, 0, 1);
        add(0, 0, 2, 0, 0, 1);
        add(0, 0, 2, 0, 0, 1);
        add(0, 1, 2, 0, 0, 1);
        add(0, 1, 2, 1, 1, 1);

        edge_wait();
        edge_wait();

        for (int i = 0; i < vecs.size(); i++) begin
            RST = vecs[i].rst;
            EN  = vecs[i].en;
            DIV = vecs[i].div;
            edge_wait();
            chk("tbl_y", i, 32'(Y), 32'(vecs[i].y));
            chk("tbl_pulse", i, 32'(PULSE), 32'(vecs[i].pulse));
            chk("tbl_active", i, 32'(ACTIVE), 32'(vecs[i].active));
        end

        // DIV=2 running, then DIV=5 applied during the second high cycle: 3H/3L, then 6H/6L.
        RST = 1'b1;
        EN  = 1'b1;
        DIV = WIDTH'(2);
        edge_wait();
        RST = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            edge_wait();
            exp_y = (k <= 3) || (k >= 7 && k <= 12) || (k == 19);
            exp_p = (k == 1) || (k == 7) || (k == 19);
            chk("divchg_y", k, 32'(Y), 32'(exp_y));
            chk("divchg_pulse", k, 32'(PULSE), 32'(exp_p));
            if (k == 2) DIV = WIDTH'(5);
        end

        // DIV=255: 256 high, 256 low, the counter topping out at 255 without wrapping.
        RST = 1'b1;
        EN  = 1'b1;
        DIV = WIDTH'(255);
        edge_wait();
        RST = 1'b0;
        max_cnt = 0;
        for (int k = 1; k <= 513; k++) begin
            edge_wait();
            exp_y = (k <= 256) || (k == 513);
            exp_p = (k == 1) || (k == 513);
            chk("div255_y", k, 32'(Y), 32'(exp_y));
            chk("div255_pulse", k, 32'(PULSE), 32'(exp_p));
            if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
        end
        chk("div255_cnt_peak", 0, 32'(max_cnt), 32'd255);
        chk("div255_active", 0, 32'(ACTIVE), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_12t_clkdiv.md
GF180MCU_OSU_SC_12T_CLKDIV -- requirements
Module: gf180mcu_osu_sc_12T_clkdiv

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, bit width of DIV and the internal phase counter; legal range 1..16.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port EN, input, 1, run request for the divided clock.
REQ-005 The block SHALL have port DIV, input, WIDTH, half-period minus one, in CLK cycles.
REQ-006 The block SHALL have port Y, output, 1, registered divided clock.
REQ-007 The block SHALL have port PULSE, output, 1, one-CLK-cycle strobe coincident with each Y rising edge.
REQ-008 The block SHALL have port ACTIVE, output, 1, high whenever the divider is not idle.

Function
REQ-009 The block SHALL hold these registers: state (IDLE/HIGH/LOW), cnt[WIDTH], div_q[WIDTH], Y, PULSE; all outputs registered, no combinational path from input to output.
REQ-010 In IDLE with EN=1, the block SHALL, next edge: state<-HIGH, Y<-1, PULSE<-1, div_q<-DIV, cnt<-0.
REQ-011 In IDLE with EN=0, the block SHALL hold Y=0, PULSE=0, cnt=0.
REQ-012 In HIGH, if cnt==div_q, the block SHALL: state<-LOW, Y<-0, cnt<-0; otherwise cnt<-cnt+1.
REQ-013 In LOW, if cnt!=div_q, the block SHALL: cnt<-cnt+1, with Y held at 0.
REQ-014 In LOW with cnt==div_q and EN=1, the block SHALL: state<-HIGH, Y<-1, PULSE<-1, div_q<-DIV, cnt<-0, with no idle gap.
REQ-015 In LOW with cnt==div_q and EN=0, the block SHALL: state<-IDLE, cnt<-0, Y stays 0.
REQ-016 PULSE SHALL be 0 on every edge not listed in REQ-010/REQ-014 (exactly one cycle wide).
REQ-017 Y SHALL be high for exactly div_q+1 cycles and low for exactly div_q+1 cycles; period 2*(div_q+1).
REQ-018 DIV SHALL be sampled only at a Y rising edge (REQ-010/REQ-014); mid-period DIV changes SHALL NOT alter the current period.
REQ-019 DIV=0 SHALL give Y toggling every CLK cycle (period 2); DIV=2^WIDTH-1 SHALL give period 2^(WIDTH+1) with no counter overflow (compare before increment).
REQ-020 EN deassertion in HIGH or LOW SHALL NOT truncate any phase: the current high and low phases complete, then IDLE (glitch-free stop).
REQ-021 EN reasserted before the final LOW cycle SHALL be equivalent to EN never dropping.
REQ-022 ACTIVE SHALL equal (state!=IDLE), registered with state.

Reset
REQ-023 RST=1 at an edge SHALL force state=IDLE, cnt=0, div_q=0, Y=0, PULSE=0, ACTIVE=0, overriding EN.
REQ-024 RST asserted mid-period SHALL take effect at that edge even if it shortens the current Y phase.
REQ-025 After RST deasserts with EN=1, the first Y rise and PULSE SHALL occur on the first edge with RST=0.

Verification
REQ-026 WIDTH=8, DIV=3, EN=1 from reset release -> Y: 4 high, 4 low, repeating; PULSE high on each rise only; ACTIVE=1.
REQ-027 DIV=0, EN=1 -> Y toggles every cycle; PULSE high every second cycle.
REQ-028 DIV=2 running, DIV changed to 5 on 2nd high cycle -> current period 3H/3L, next period 6H/6L.
REQ-029 DIV=4, EN dropped on 1st high cycle -> 5H then 5L complete, then IDLE, ACTIVE=0, Y=0, no PULSE.
REQ-030 DIV=255 -> period 512 cycles, cnt peaks at 255, no wrap.
REQ-031 DIV=3, RST on 2nd high cycle -> next edge Y=0, PULSE=0, ACTIVE=0; after release with EN=1, Y rises on first edge.
